fmac_norm_shift: RTL

Normalization stage of the FMAC datapath, consuming the leading-one anticipation result. It receives the magnitude of the wide addition result, the anticipated leading-one shift count and the no-one flag. It left-shifts the mantissa by the anticipated count, then applies the one-position anticipation correction and adjusts the exponent. It is a two-stage valid/ready pipeline between the adder/LZA stage and the rounding stage.

---
 rtl/fmac_norm_shift.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fmac_norm_shift.sv
// FMAC normalization stage: shifts the adder magnitude by the anticipated leading-one
// count, fixes the one-position under-shift and adjusts the exponent, in a 2-deep valid/ready pipe.
module fmac_norm_shift #(
    parameter int unsigned C_WIDTH         = 74,
    parameter int unsigned C_LEADONE_WIDTH = 7,
    parameter int unsigned C_EXP_WIDTH     = 10
) (
    input  logic                       Clk_CI,
    input  logic                       Rst_RI,
    input  logic                       Flush_SI,
    input  logic                       In_Valid_SI,
    output logic                       In_Ready_SO,
    input  logic [C_WIDTH-1:0]         Mant_DI,
    input  logic [C_LEADONE_WIDTH-1:0] LeadOne_DI,
    input  logic                       NoOne_SI,
    input  logic [C_EXP_WIDTH-1:0]     Exp_DI,
    output logic                       Out_Valid_SO,
    input  logic                       Out_Ready_SI,
    output logic [C_WIDTH-1:0]         Mant_DO,
    output logic [C_EXP_WIDTH-1:0]     Exp_DO,
    output logic                       Zero_SO,
    output logic                       Corr_SO
);

    localparam logic [C_LEADONE_WIDTH-1:0] MAX_SHIFT = C_LEADONE_WIDTH'(C_WIDTH - 1);

    // Handshake: a stage takes a new beat when it is empty or when the stage after it
    // is advancing in the same cycle; a beat moves on an edge where valid and ready are both high.
    logic en1, en2;
    logic v1_q, v2_q;

    logic [C_WIDTH-1:0]         m1_q;
    logic [C_EXP_WIDTH-1:0]     e1_q;
    logic                       z1_q;

    logic [C_WIDTH-1:0]         mant_q;
    logic [C_EXP_WIDTH-1:0]     exp_q;
    logic                       zero_q;
    logic                       corr_q;

    logic [C_LEADONE_WIDTH-1:0] sh_d;
    logic [C_WIDTH-1:0]         m1_d;
    logic [C_EXP_WIDTH-1:0]     e1_d;
    logic                       z1_d;

    logic [C_WIDTH-1:0]         mant_d;
    logic [C_EXP_WIDTH-1:0]     exp_d;
    logic                       zero_d;
    logic                       corr_d;

    assign en2         = ~v2_q | Out_Ready_SI;
    assign en1         = ~v1_q | en2;
    assign In_Ready_SO = en1;

    always_comb begin
        sh_d = (LeadOne_DI > MAX_SHIFT) ? MAX_SHIFT : LeadOne_DI;
        m1_d = Mant_DI << sh_d;
        e1_d = Exp_DI - C_EXP_WIDTH'(sh_d);
        z1_d = NoOne_SI | (Mant_DI == '0);
    end

    // The anticipator may land one position short; a clear MSB after stage 1 means exactly that.
    always_comb begin
        mant_d = m1_q;
        exp_d  = e1_q;
        zero_d = 1'b0;
        corr_d = 1'b0;
        if (z1_q) begin
            mant_d = '0;
            exp_d  = '0;
            zero_d = 1'b1;
        end else if (!m1_q[C_WIDTH-1]) begin
            mant_d = {m1_q[C_WIDTH-2:0], 1'b0};
            exp_d  = e1_q - C_EXP_WIDTH'(1);
            corr_d = 1'b1;
        end
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else if (Flush_SI) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            if (en1) v1_q <= In_Valid_SI;
            if (en2) v2_q <= v1_q;
        end
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            m1_q   <= '0;
            e1_q   <= '0;
            z1_q   <= 1'b0;
            mant_q <= '0;
            exp_q  <= '0;
            zero_q <= 1'b0;
            corr_q <= 1'b0;
        end else if (!Flush_SI) begin
            if (en1) begin
                m1_q <= m1_d;
                e1_q <= e1_d;
                z1_q <= z1_d;
            end
            if (en2) begin
                mant_q <= mant_d;
                exp_q  <= exp_d;
                zero_q <= zero_d;
                corr_q <= corr_d;
            end
        end
    end

    assign Out_Valid_SO = v2_q;
    assign Mant_DO      = mant_q;
    assign Exp_DO       = exp_q;
    assign Zero_SO      = zero_q;
    assign Corr_SO      = corr_q;

endmodule
